// File: rtl/sram_ctrl_p.sv
// sram_ctrl_p: parametrised single-port SRAM with post-reset clear, pipelined reads and error strobe
module sram_ctrl_p #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int RD_LAT     = 1,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs,
    input  logic                we,
    input  logic                re,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wbe,
    output logic                req_ready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                init_done,
    output logic                err
);
    localparam int NB = DATA_W / 8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [DATA_W-1:0] dat_q [RD_LAT];
    logic [DATA_W-1:0] dat_d [RD_LAT];
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              last, acc, in_range, rd_en, wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data, rd_word;
    logic [NB-1:0]     wr_be;

    // clear sequencer: one word per cycle from 0 to DEPTH-1, then ready until the next reset
    always_comb begin
        last    = state_q == CLEAR && cnt_q == ADDR_W'(DEPTH - 1);
        state_d = last ? READY : state_q;
        cnt_d   = state_q == CLEAR ? cnt_q + 1'b1 : cnt_q;
        done_d  = state_q == READY || last;
    end

    // request decode; the write port is owned by the clear sequencer until it finishes
    always_comb begin
        in_range = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
        acc      = done_q && cs && (we || re);
        rd_en    = acc && re && !we;
        wr_en    = state_q == CLEAR || (acc && we && in_range);
        wr_addr  = state_q == CLEAR ? cnt_q : addr;
        wr_data  = state_q == CLEAR ? '0 : wdata;
        wr_be    = state_q == CLEAR ? '1 : wbe;
        rd_word  = in_range ? mem_q[addr] : '0;
        err_d    = acc && ((we && re) || !in_range);
    end

    // read pipeline: data moves only alongside its valid so rdata holds between reads
    always_comb begin
        vld_d[0] = rd_en;
        dat_d[0] = rd_en ? rd_word : dat_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    // control, pipeline and error registers; reset flushes in-flight reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT_CLEAR ? CLEAR : READY;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= dat_d[i];
        end
    end

    // storage with byte enables; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && wr_en)
            for (int b = 0; b < NB; b++)
                if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end

    assign req_ready = done_q;
    assign init_done = done_q;
    assign err       = err_q;
    assign rvalid    = vld_q[RD_LAT-1];
    assign rdata     = dat_q[RD_LAT-1];
endmodule

// File: tb/tb_sram_ctrl_p.sv
// tb_sram_ctrl_p: three configurations driven in lockstep against a behavioural model
module tb_sram_ctrl_p;
    logic        clk, rst_n, cs, we, re;
    logic [3:0]  addr;
    logic [23:0] wdata;
    logic [2:0]  wbe;
    int cmp = 0;
    int bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", n, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int DW   = g == 0 ? 8 : (g == 1 ? 16 : 24);
        localparam int NB   = DW / 8;
        localparam int DEP  = g == 1 ? 12 : 16;
        localparam int LAT  = g == 0 ? 1 : (g == 1 ? 3 : 2);
        localparam int IC   = g == 1 ? 0 : 1;
        localparam int RDY0 = IC != 0 ? DEP : 1;

        logic          rdy, rv, idn, er;
        logic [DW-1:0] rd;

        sram_ctrl_p #(.DATA_W(DW), .ADDR_W(4), .DEPTH(DEP), .RD_LAT(LAT), .INIT_CLEAR(IC != 0)) dut (
            .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .re(re), .addr(addr),
            .wdata(wdata[DW-1:0]), .wbe(wbe[NB-1:0]), .req_ready(rdy), .rdata(rd),
            .rvalid(rv), .init_done(idn), .err(er)
        );

        logic [DW-1:0] m  [16];
        logic [NB-1:0] kn [16];
        int            qd [$];
        logic [DW-1:0] qv [$];
        logic [NB-1:0] qk [$];
        int            rel, cyc;
        bit            seen;
        logic          e_v, e_er, e_rdy;
        logic [DW-1:0] e_d;
        logic [NB-1:0] e_k;

        initial begin
            bit acc, inr;
            seen = 0; rel = 0; cyc = 0;
            e_v = 0; e_er = 0; e_rdy = 0; e_d = '0; e_k = '1;
            for (int i = 0; i < 16; i++) kn[i] = '0;
            forever begin
                @(posedge clk);
                if (!rst_n) begin
                    seen = 1; rel = 0;
                    qd.delete(); qv.delete(); qk.delete();
                    e_v = 0; e_er = 0; e_d = '0; e_k = '1;
                end else begin
                    acc = rel >= RDY0 && cs && (we || re);
                    inr = int'(addr) < DEP;
                    if (IC != 0 && rel < DEP) begin
                        m[rel] = '0;
                        kn[rel] = '1;
                    end
                    if (acc && re && !we) begin
                        qd.push_back(cyc + LAT - 1);
                        qv.push_back(inr ? m[addr] : '0);
                        qk.push_back(inr ? kn[addr] : '1);
                    end
                    if (acc && we && inr)
                        for (int b = 0; b < NB; b++)
                            if (wbe[b]) begin
                                m[addr][8*b +: 8] = wdata[8*b +: 8];
                                kn[addr][b] = 1'b1;
                            end
                    e_er = acc && ((we && re) || !inr);
                    rel++;
                    e_v = 0;
                    if (qd.size() > 0 && qd[0] == cyc) begin
                        e_v = 1;
                        e_d = qv.pop_front();
                        e_k = qk.pop_front();
                        void'(qd.pop_front());
                    end
                end
                e_rdy = rel >= RDY0;
                cyc++;
            end
        end

        always @(negedge clk) begin
            logic [DW-1:0] bm;
            for (int b = 0; b < NB; b++) bm[8*b +: 8] = {8{e_k[b]}};
            if (seen) begin
                chk($sformatf("cfg%0d.req_ready", g), 32'(rdy), 32'(e_rdy));
                chk($sformatf("cfg%0d.init_done", g), 32'(idn), 32'(e_rdy));
                chk($sformatf("cfg%0d.rvalid", g), 32'(rv), 32'(e_v));
                chk($sformatf("cfg%0d.err", g), 32'(er), 32'(e_er));
                chk($sformatf("cfg%0d.rdata", g), 32'(rd & bm), 32'(e_d & bm));
            end
        end
    end

    task automatic drive(input logic c, input logic w, input logic r, input logic [3:0] a,
                         input logic [23:0] d, input logic [2:0] be);
        @(negedge clk);
        cs = c; we = w; re = r; addr = a; wdata = d; wbe = be;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 4'd0, 24'd0, 3'd0);
    endtask

    initial begin
        rst_n = 0; cs = 0; we = 0; re = 0; addr = '0; wdata = '0; wbe = '0;
        idle(3);
        rst_n = 1;
        idle(15);
        chk("t1 ready low during clear", 32'(cfg[0].rdy), 32'd0);
        idle(1);
        chk("t1 ready after clear", 32'(cfg[0].rdy), 32'd1);
        chk("t1 init_done after clear", 32'(cfg[0].idn), 32'd1);
        for (int i = 0; i < 16; i++) drive(1, 0, 1, 4'(i), 24'd0, 3'd0);
        idle(4);
        for (int i = 0; i < 16; i++) drive(1, 1, 0, 4'(i), 24'($urandom), 3'b111);
        idle(2);

        drive(1, 1, 0, 4'd3, 24'h0000A5, 3'b111);
        drive(1, 0, 1, 4'd3, 24'd0, 3'd0);
        idle(1);
        chk("t2 rvalid", 32'(cfg[0].rv), 32'd1);
        chk("t2 rdata", 32'(cfg[0].rd), 32'hA5);
        idle(4);

        drive(1, 1, 0, 4'd5, 24'h001234, 3'b011);
        drive(1, 1, 0, 4'd5, 24'h00ABCD, 3'b001);
        drive(1, 0, 1, 4'd5, 24'd0, 3'd0);
        idle(3);
        chk("t3 rvalid", 32'(cfg[1].rv), 32'd1);
        chk("t3 rdata", 32'(cfg[1].rd), 32'h12CD);
        idle(4);

        drive(1, 1, 0, 4'd1, 24'h001111, 3'b111);
        drive(1, 1, 0, 4'd2, 24'h002222, 3'b111);
        drive(1, 1, 0, 4'd3, 24'h003333, 3'b111);
        drive(1, 0, 1, 4'd1, 24'd0, 3'd0);
        drive(1, 0, 1, 4'd2, 24'd0, 3'd0);
        drive(1, 0, 1, 4'd3, 24'd0, 3'd0);
        chk("t4 no early rvalid", 32'(cfg[1].rv), 32'd0);
        idle(1);
        chk("t4 first rvalid", 32'(cfg[1].rv), 32'd1);
        chk("t4 first rdata", 32'(cfg[1].rd), 32'h1111);
        idle(1);
        chk("t4 second rdata", 32'(cfg[1].rd), 32'h2222);
        idle(1);
        chk("t4 third rvalid", 32'(cfg[1].rv), 32'd1);
        chk("t4 third rdata", 32'(cfg[1].rd), 32'h3333);
        idle(1);
        chk("t4 rvalid drops", 32'(cfg[1].rv), 32'd0);
        chk("t4 rdata holds", 32'(cfg[1].rd), 32'h3333);
        idle(4);

        drive(1, 1, 1, 4'd7, 24'h00003C, 3'b111);
        idle(1);
        chk("t5 collision err", 32'(cfg[0].er), 32'd1);
        chk("t5 collision no rvalid", 32'(cfg[0].rv), 32'd0);
        drive(1, 0, 1, 4'd7, 24'd0, 3'd0);
        idle(1);
        chk("t5 readback rvalid", 32'(cfg[0].rv), 32'd1);
        chk("t5 readback rdata", 32'(cfg[0].rd), 32'h3C);
        idle(4);

        drive(1, 0, 1, 4'd14, 24'd0, 3'd0);
        idle(1);
        chk("t6 out-of-range err", 32'(cfg[1].er), 32'd1);
        chk("t6 in-range no err", 32'(cfg[0].er), 32'd0);
        idle(2);
        chk("t6 out-of-range rvalid", 32'(cfg[1].rv), 32'd1);
        chk("t6 out-of-range rdata", 32'(cfg[1].rd), 32'd0);
        idle(4);

        drive(1, 0, 1, 4'd2, 24'd0, 3'd0);
        idle(1);
        rst_n = 0;
        idle(1);
        chk("t6 reset kills rvalid", 32'(cfg[2].rv), 32'd0);
        idle(1);
        rst_n = 1;
        idle(5);
        rst_n = 0;
        idle(2);
        rst_n = 1;
        idle(15);
        chk("t6 clear restarted", 32'(cfg[0].rdy), 32'd0);
        idle(2);
        for (int i = 0; i < 16; i++) drive(1, 0, 1, 4'(i), 24'd0, 3'd0);
        idle(4);

        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) begin
                idle(1);
                rst_n = 0;
                idle($urandom_range(1, 2));
                rst_n = 1;
            end else begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                      4'($urandom_range(0, 15)), 24'($urandom), 3'($urandom_range(0, 7)));
            end
        end
        idle(6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
